hc32_share_arb: RTL and testbench

//   Round-robin arbiter and sequencer that shares one external 74HC32 quad
//   2-input OR resource (4-bit A/B in, 4-bit Y out) among N_REQ requesters.

---
 rtl/hc32_share_arb.sv | 154 +++++++++++++++
 tb/tb_hc32_share_arb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hc32_share_arb.sv
// Round-robin arbiter that time-shares one external 74HC32 quad OR gate among
// N_REQ requesters: grant, drive operands, settle, capture Y, acknowledge.
module hc32_share_arb #(
    parameter int N_REQ      = 4,
    parameter int WIDTH      = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_REQ-1:0]           i_req,
    input  logic [N_REQ*WIDTH-1:0]     i_opa,
    input  logic [N_REQ*WIDTH-1:0]     i_opb,
    output logic [N_REQ-1:0]           o_ack,
    output logic [WIDTH-1:0]           o_result,
    output logic                       o_res_valid,
    output logic [$clog2(N_REQ)-1:0]   o_res_id,
    output logic                       o_busy,
    output logic [WIDTH-1:0]           o_or_a,
    output logic [WIDTH-1:0]           o_or_b,
    input  logic [WIDTH-1:0]           i_or_y
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_gnt;
    logic [CW-1:0]       r_cnt;
    logic [N_REQ-1:0]    r_ack;
    logic [WIDTH-1:0]    r_result;
    logic                r_res_valid;
    logic [IW-1:0]       r_res_id;
    logic                r_busy;
    logic [WIDTH-1:0]    r_or_a;
    logic [WIDTH-1:0]    r_or_b;

    logic                w_pick_vld;
    logic [IW-1:0]       w_pick;
    logic [IW-1:0]       w_ptr_next;
    logic [WIDTH-1:0]    w_opa_arr [N_REQ];
    logic [WIDTH-1:0]    w_opb_arr [N_REQ];

    // First requesting index at or after ptr, wrapping modulo N_REQ.
    function automatic logic [IW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [IW-1:0]    ptr);
        logic [IW-1:0] pick;
        int            idx;
        pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (req[idx]) begin
                pick = IW'(idx);
            end
        end
        return pick;
    endfunction

    // Unpack the flat operand buses into per-requester slices.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_opa_arr[i] = i_opa[i*WIDTH +: WIDTH];
            w_opb_arr[i] = i_opb[i*WIDTH +: WIDTH];
        end
    end

    // Arbitration choice and the pointer value that follows the current grant.
    always_comb begin
        w_pick_vld = |i_req;
        w_pick     = rr_pick(i_req, r_ptr);
        if (r_gnt == IW'(N_REQ - 1)) begin
            w_ptr_next = '0;
        end else begin
            w_ptr_next = r_gnt + IW'(1);
        end
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_cnt       <= '0;
            r_ack       <= '0;
            r_result    <= '0;
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_busy      <= 1'b0;
            r_or_a      <= '0;
            r_or_b      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_gnt   <= w_pick;
                        r_or_a  <= w_opa_arr[w_pick];
                        r_or_b  <= w_opb_arr[w_pick];
                        r_cnt   <= CW'(SETTLE_CYC - 1);
                        r_busy  <= 1'b1;
                        r_state <= ST_DRIVE;
                    end else begin
                        r_or_a  <= '0;
                        r_or_b  <= '0;
                    end
                end
                ST_DRIVE: begin
                    // Operands stay put; Y is sampled only once the settle time elapses.
                    if (r_cnt == '0) begin
                        r_result    <= i_or_y;
                        r_res_id    <= r_gnt;
                        r_ack       <= {{(N_REQ-1){1'b0}}, 1'b1} << r_gnt;
                        r_res_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_DONE: begin
                    r_ack       <= '0;
                    r_res_valid <= 1'b0;
                    r_or_a      <= '0;
                    r_or_b      <= '0;
                    r_busy      <= 1'b0;
                    r_ptr       <= w_ptr_next;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_ack       <= '0;
                    r_res_valid <= 1'b0;
                    r_or_a      <= '0;
                    r_or_b      <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_ack       = r_ack;
    assign o_result    = r_result;
    assign o_res_valid = r_res_valid;
    assign o_res_id    = r_res_id;
    assign o_busy      = r_busy;
    assign o_or_a      = r_or_a;
    assign o_or_b      = r_or_b;

endmodule

// File: tb/tb_hc32_share_arb.sv
// Scoreboard bench for hc32_share_arb: models the HC32 with one cycle of delay
// and checks grant order, timing and captured results.
module tb_hc32_share_arb;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int SC = 2;

    typedef struct {
        int         id;
        logic [3:0] res;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N*W-1:0] opa;
    logic [N*W-1:0] opb;
    logic [N-1:0]  ack;
    logic [W-1:0]  result;
    logic          res_valid;
    logic [1:0]    res_id;
    logic          busy;
    logic [W-1:0]  or_a;
    logic [W-1:0]  or_b;
    logic [W-1:0]  y_dly = 4'b0000;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb[$];

    hc32_share_arb #(.N_REQ(N), .WIDTH(W), .SETTLE_CYC(SC)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_opa       (opa),
        .i_opb       (opb),
        .o_ack       (ack),
        .o_result    (result),
        .o_res_valid (res_valid),
        .o_res_id    (res_id),
        .o_busy      (busy),
        .o_or_a      (or_a),
        .o_or_b      (or_b),
        .i_or_y      (y_dly)
    );

    always #5 clk = ~clk;

    // External OR gate with one cycle of propagation delay.
    always @(posedge clk) y_dly <= or_a | or_b;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
        opa[i*W +: W] = a;
        opb[i*W +: W] = b;
    endtask

    task automatic push(input int id, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        e.id  = id;
        e.res = a | b;
        sb.push_back(e);
    endtask

    // Wait (bounded) for RES_VALID, then pop the scoreboard and compare.
    task automatic wait_ack(input string tag, output int lat, output int t_seen);
        bit   seen;
        bit   queued;
        exp_t e;
        seen   = 1'b0;
        lat    = 0;
        t_seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            lat++;
            if (res_valid) begin
                seen   = 1'b1;
                t_seen = cyc;
            end
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        queued = (sb.size() != 0);
        chk({tag, "_queued"}, 32'(queued), 32'd1);
        if (seen && queued) begin
            e = sb.pop_front();
            chk({tag, "_id"}, 32'(res_id), 32'(e.id));
            chk({tag, "_ack"}, 32'(ack), 32'(4'b0001 << e.id));
            chk({tag, "_result"}, 32'(result), 32'(e.res));
        end
    endtask

    initial begin
        int lat;
        int t0;
        int t1;
        rst_n = 1'b0;
        req   = '0;
        opa   = '0;
        opb   = '0;

        // Reset state
        #12;
        chk("reset_outs", {ack, result, res_valid, res_id, busy, or_a, or_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request from requester 0
        set_op(0, 4'b1010, 4'b0101);
        req = 4'b0001;
        push(0, 4'b1010, 4'b0101);
        @(negedge clk);
        chk("single_or_a0", 32'(or_a), 32'hA);
        chk("single_or_b0", 32'(or_b), 32'h5);
        chk("single_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("single_or_a1", 32'(or_a), 32'hA);
        chk("single_ack_early", 32'(res_valid), 32'd0);
        wait_ack("single", lat, t0);
        chk("single_latency", 32'(2 + lat), 32'(SC + 1));
        req = 4'b0000;
        @(negedge clk);
        chk("single_pulse", 32'(res_valid), 32'd0);
        chk("single_hold_res", 32'(result), 32'hF);
        chk("single_hold_id", 32'(res_id), 32'd0);
        chk("single_or_clr", 32'({or_a, or_b}), 32'd0);
        chk("single_idle", 32'(busy), 32'd0);

        // Reset asserted mid-DRIVE
        set_op(0, 4'b0110, 4'b0000);
        req = 4'b0001;
        @(negedge clk);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {ack, result, res_valid, res_id, busy, or_a, or_b}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_no_ack", 32'({ack, res_valid}), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_idle", 32'(busy), 32'd0);

        // Round-robin under continuous load: order 0,1,2,3,0, spaced SC+2
        for (int i = 0; i < N; i++) set_op(i, 4'(i), 4'(4'b1000 >> i));
        push(0, 4'h0, 4'h8);
        push(1, 4'h1, 4'h4);
        push(2, 4'h2, 4'h2);
        push(3, 4'h3, 4'h1);
        push(0, 4'h0, 4'h8);
        req = 4'b1111;
        t1 = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ack("rr", lat, t0);
            if (k > 0) chk("rr_spacing", 32'(t0 - t1), 32'(SC + 2));
            t1 = t0;
        end
        req = 4'b0000;
        @(negedge clk);

        // Move pointer to 3, then 1001 must grant 3 before 0
        set_op(2, 4'b0010, 4'b0000);
        req = 4'b0100;
        push(2, 4'b0010, 4'b0000);
        wait_ack("wrap_pre", lat, t0);
        req = 4'b0000;
        @(negedge clk);
        set_op(3, 4'b1100, 4'b0000);
        set_op(0, 4'b0001, 4'b0010);
        push(3, 4'b1100, 4'b0000);
        push(0, 4'b0001, 4'b0010);
        req = 4'b1001;
        wait_ack("wrap3", lat, t0);
        req[3] = 1'b0;
        wait_ack("wrap0", lat, t0);
        req[0] = 1'b0;
        @(negedge clk);

        // Settle capture through the delayed OR model
        set_op(1, 4'b0011, 4'b0100);
        req = 4'b0010;
        push(1, 4'b0011, 4'b0100);
        wait_ack("settle", lat, t0);
        req = 4'b0000;
        @(negedge clk);

        // REQ dropped mid-DRIVE, operands changed after grant
        set_op(2, 4'b1000, 4'b0001);
        req = 4'b0100;
        push(2, 4'b1000, 4'b0001);
        @(negedge clk);
        chk("drop_busy", 32'(busy), 32'd1);
        req = 4'b0000;
        set_op(2, 4'b1111, 4'b1111);
        wait_ack("drop", lat, t0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drop_idle", 32'({busy, res_valid}), 32'd0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
